// File: rtl/lab2_mux4.sv
`default_nettype none
// ============================================================================
// Module      : lab2_mux4
// Description : Registered 4-to-1 lane multiplexer with a valid qualifier.
//               One-cycle latency, throughput of one selection per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module lab2_mux4 #(
    parameter int WIDTH = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4*WIDTH-1:0] din,
    input  logic [1:0]         sel,
    input  logic               in_valid,
    output logic [WIDTH-1:0]   dout,
    output logic               out_valid
);

    localparam int c_LANES = 4;

    logic [WIDTH-1:0] w_lane [c_LANES];
    logic [WIDTH-1:0] w_selected;
    logic [WIDTH-1:0] r_dout;
    logic             r_valid;

    generate
        for (genvar g = 0; g < c_LANES; g++) begin : g_lane
            assign w_lane[g] = din[g*WIDTH +: WIDTH];
        end
    endgenerate

    // Any non-binary select (X/Z) falls through to lane a.
    always_comb begin
        w_selected = w_lane[0];
        case (sel)
            2'b00:   w_selected = w_lane[0];
            2'b01:   w_selected = w_lane[1];
            2'b10:   w_selected = w_lane[2];
            2'b11:   w_selected = w_lane[3];
            default: w_selected = w_lane[0];
        endcase
    end

    // dout only moves on a valid input; out_valid tracks in_valid with one cycle lag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_dout <= w_selected;
            end
        end
    end

    assign dout      = r_dout;
    assign out_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_lab2_mux4.sv
`default_nettype none
// ============================================================================
// Module      : tb_lab2_mux4
// Description : Directed self-checking bench for lab2_mux4 at WIDTH=1 and WIDTH=8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lab2_mux4;

    logic        clk = 1'b0;
    logic        rst;

    logic [3:0]  din1;
    logic [1:0]  sel1;
    logic        vin1;
    logic [0:0]  dout1;
    logic        vout1;

    logic [31:0] din8;
    logic [1:0]  sel8;
    logic        vin8;
    logic [7:0]  dout8;
    logic        vout8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lab2_mux4 #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .din       (din1),
        .sel       (sel1),
        .in_valid  (vin1),
        .dout      (dout1),
        .out_valid (vout1)
    );

    lab2_mux4 #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .din       (din8),
        .sel       (sel8),
        .in_valid  (vin8),
        .dout      (dout8),
        .out_valid (vout8)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] v;

        // Reset with valid all-ones inputs on both instances
        rst  = 1'b1;
        din1 = 4'hF;       sel1 = 2'b11; vin1 = 1'b1;
        din8 = 32'hFFFF_FFFF; sel8 = 2'b11; vin8 = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            check("rst_dout1", {31'd0, dout1}, 32'd0);
            check("rst_vout1", {31'd0, vout1}, 32'd0);
            check("rst_dout8", {24'd0, dout8}, 32'd0);
            check("rst_vout8", {31'd0, vout8}, 32'd0);
        end
        rst  = 1'b0;
        vin8 = 1'b0;

        // Exhaustive WIDTH=1
        for (int i = 0; i < 16; i++) begin
            for (int s = 0; s < 4; s++) begin
                v    = i[3:0];
                din1 = v;
                sel1 = s[1:0];
                vin1 = 1'b1;
                step();
                check("exh_dout1", {31'd0, dout1}, {31'd0, v[s]});
                check("exh_vout1", {31'd0, vout1}, 32'd1);
            end
        end
        vin1 = 1'b0;
        step();
        check("exh_idle_vout1", {31'd0, vout1}, 32'd0);

        // WIDTH=8 lane selection: {d,c,b,a} = {44,33,22,11}
        din8 = 32'h4433_2211; sel8 = 2'b10; vin8 = 1'b1;
        step();
        check("w8_sel10", {24'd0, dout8}, 32'h33);
        check("w8_sel10_v", {31'd0, vout8}, 32'd1);
        sel8 = 2'b11;
        step();
        check("w8_sel11", {24'd0, dout8}, 32'h44);

        // Hold: dout stays while in_valid is low despite din/sel changes
        sel8 = 2'b01;
        step();
        check("hold_pre", {24'd0, dout8}, 32'h22);
        vin8 = 1'b0; din8 = 32'hAABB_CCDD; sel8 = 2'b11;
        step();
        check("hold_dout", {24'd0, dout8}, 32'h22);
        check("hold_vout", {31'd0, vout8}, 32'd0);
        din8 = 32'h0102_0304; sel8 = 2'b00;
        step();
        check("hold_dout2", {24'd0, dout8}, 32'h22);

        // Back-to-back sweep 00,01,10,11 with {d,c,b,a} = {D4,C3,B2,A1}
        din8 = 32'hD4C3_B2A1; vin8 = 1'b1;
        sel8 = 2'b00; step(); check("b2b_a", {24'd0, dout8}, 32'hA1); check("b2b_va", {31'd0, vout8}, 32'd1);
        sel8 = 2'b01; step(); check("b2b_b", {24'd0, dout8}, 32'hB2); check("b2b_vb", {31'd0, vout8}, 32'd1);
        sel8 = 2'b10; step(); check("b2b_c", {24'd0, dout8}, 32'hC3); check("b2b_vc", {31'd0, vout8}, 32'd1);
        sel8 = 2'b11; step(); check("b2b_d", {24'd0, dout8}, 32'hD4); check("b2b_vd", {31'd0, vout8}, 32'd1);
        vin8 = 1'b0;
        step();
        check("b2b_end_v", {31'd0, vout8}, 32'd0);

        // Reset collision: valid input during rst is discarded
        rst = 1'b1; vin8 = 1'b1; sel8 = 2'b11; din8 = 32'hFF00_0000;
        step();
        check("coll_dout", {24'd0, dout8}, 32'h00);
        check("coll_vout", {31'd0, vout8}, 32'd0);
        rst = 1'b0; vin8 = 1'b0;
        step();
        check("post_rst_dout", {24'd0, dout8}, 32'h00);
        check("post_rst_vout", {31'd0, vout8}, 32'd0);
        vin8 = 1'b1; sel8 = 2'b01; din8 = 32'h0000_5A00;
        step();
        check("first_after_rst", {24'd0, dout8}, 32'h5A);
        check("first_after_rst_v", {31'd0, vout8}, 32'd1);
        vin8 = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
